// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the MIPS pipeline.
//   Latches one retiring instruction from the memory stage and commits it the following cycle:
//   GPR write port, CP0 write / exception / ERET bus, and the combinational MFC0 read path.
//   An exception or ERET commit raises ws_flush for one cycle to squash all upstream stages.
// Ports:
//   clock, reset (synchronous, active-high)
//   ms_*           instruction payload and handshake from the memory stage
//   ws_allow_in    this stage accepts an instruction this cycle
//   cp0_*          CP0 write / address / exception / eret bus; cp0_read_data is the CP0 read result
//   ws_flush       squash upstream stages
//   rf_*           GPR write port
//   ws_fwd_*       bypass / stall information for decode
// Optional feature: macro WB_DEBUG_TRACE_EN adds debug_wb_pc, debug_wb_rf_wen,
//   debug_wb_rf_wnum and debug_wb_rf_wdata trace outputs.
module writeback_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ms_to_ws_valid,
  output logic                      ws_allow_in,
  input  logic [DATA_WIDTH-1:0]     ms_pc,
  input  logic [DATA_WIDTH-1:0]     ms_result,
  input  logic [REG_ADDR_WIDTH-1:0] ms_dest,
  input  logic                      ms_reg_write,
  input  logic                      ms_exception_valid,
  input  logic [4:0]                ms_exception_code,
  input  logic                      ms_in_delay_slot,
  input  logic                      ms_eret,
  input  logic                      ms_mfc0,
  input  logic                      ms_mtc0,
  input  logic [4:0]                ms_cp0_reg,
  input  logic [2:0]                ms_cp0_sel,
  input  logic [DATA_WIDTH-1:0]     cp0_read_data,
  output logic                      cp0_write_enabled,
  output logic [4:0]                cp0_address_register,
  output logic [2:0]                cp0_address_select,
  output logic [DATA_WIDTH-1:0]     cp0_write_data,
  output logic                      cp0_exception_valid,
  output logic [4:0]                cp0_exception_code,
  output logic [DATA_WIDTH-1:0]     cp0_exception_address,
  output logic                      cp0_in_delay_slot,
  output logic                      cp0_eret_flush,
  output logic                      ws_flush,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      ws_fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] ws_fwd_dest
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [DATA_WIDTH-1:0]     debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] debug_wb_rf_wnum,
  output logic [DATA_WIDTH-1:0]     debug_wb_rf_wdata
`endif
);

  // Writeback never stalls in this revision.
  localparam logic ReadyGo = 1'b1;

  logic                      ws_valid_q, ws_valid_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                      reg_write_q, reg_write_d;
  logic                      exc_q, exc_d;
  logic [4:0]                exc_code_q, exc_code_d;
  logic                      ds_q, ds_d;
  logic                      eret_q, eret_d;
  logic                      mfc0_q, mfc0_d;
  logic                      mtc0_q, mtc0_d;
  logic [4:0]                cp0_reg_q, cp0_reg_d;
  logic [2:0]                cp0_sel_q, cp0_sel_d;

  logic live;
  logic take_exc;
  logic take_eret;
  logic take_normal;

  assign ws_allow_in = ~ws_valid_q | ReadyGo;

  // Masking with reset keeps a commit from reaching CP0 or the RF in the reset cycle.
  assign live        = ws_valid_q & ~reset;
  assign take_exc    = live & exc_q;
  assign take_eret   = live & ~exc_q & eret_q;
  assign take_normal = live & ~exc_q & ~eret_q;

  always_comb begin
    ws_valid_d  = ws_valid_q;
    pc_d        = pc_q;
    result_d    = result_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    exc_d       = exc_q;
    exc_code_d  = exc_code_q;
    ds_d        = ds_q;
    eret_d      = eret_q;
    mfc0_d      = mfc0_q;
    mtc0_d      = mtc0_q;
    cp0_reg_d   = cp0_reg_q;
    cp0_sel_d   = cp0_sel_q;
    // An instruction arriving alongside a flush is dropped.
    if (ws_allow_in) begin
      ws_valid_d = ms_to_ws_valid & ~ws_flush;
    end
    if (ms_to_ws_valid && ws_allow_in) begin
      pc_d        = ms_pc;
      result_d    = ms_result;
      dest_d      = ms_dest;
      reg_write_d = ms_reg_write;
      exc_d       = ms_exception_valid;
      exc_code_d  = ms_exception_code;
      ds_d        = ms_in_delay_slot;
      eret_d      = ms_eret;
      mfc0_d      = ms_mfc0;
      mtc0_d      = ms_mtc0;
      cp0_reg_d   = ms_cp0_reg;
      cp0_sel_d   = ms_cp0_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_valid_q  <= 1'b0;
      pc_q        <= '0;
      result_q    <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      exc_q       <= 1'b0;
      exc_code_q  <= '0;
      ds_q        <= 1'b0;
      eret_q      <= 1'b0;
      mfc0_q      <= 1'b0;
      mtc0_q      <= 1'b0;
      cp0_reg_q   <= '0;
      cp0_sel_q   <= '0;
    end else begin
      ws_valid_q  <= ws_valid_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      exc_q       <= exc_d;
      exc_code_q  <= exc_code_d;
      ds_q        <= ds_d;
      eret_q      <= eret_d;
      mfc0_q      <= mfc0_d;
      mtc0_q      <= mtc0_d;
      cp0_reg_q   <= cp0_reg_d;
      cp0_sel_q   <= cp0_sel_d;
    end
  end

  always_comb begin
    cp0_exception_valid   = take_exc;
    cp0_eret_flush        = take_eret;
    ws_flush              = take_exc | take_eret;
    cp0_write_enabled     = take_normal & mtc0_q;
    rf_we                 = take_normal & reg_write_q & (dest_q != '0);
    // CP0 address stays valid for the whole commit cycle so the MFC0 read sees the right register.
    cp0_address_register  = live ? cp0_reg_q : '0;
    cp0_address_select    = live ? cp0_sel_q : '0;
    cp0_write_data        = live ? result_q : '0;
    cp0_exception_code    = live ? exc_code_q : '0;
    // Delay-slot PC adjustment is applied inside CP0.
    cp0_exception_address = live ? pc_q : '0;
    cp0_in_delay_slot     = live & ds_q;
    rf_waddr              = live ? dest_q : '0;
    rf_wdata              = '0;
    if (live) begin
      rf_wdata = mfc0_q ? cp0_read_data : result_q;
    end
    ws_fwd_valid = rf_we;
    ws_fwd_dest  = rf_waddr;
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = live ? pc_q : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: table of single-instruction vectors plus
// hand-written sequences for MTC0->MFC0, flush dropping, and reset during a commit.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc, ms_result;
  logic [4:0]  ms_dest;
  logic        ms_reg_write, ms_exception_valid;
  logic [4:0]  ms_exception_code;
  logic        ms_in_delay_slot, ms_eret, ms_mfc0, ms_mtc0;
  logic [4:0]  ms_cp0_reg;
  logic [2:0]  ms_cp0_sel;
  logic [31:0] cp0_read_data;
  logic        cp0_write_enabled;
  logic [4:0]  cp0_address_register;
  logic [2:0]  cp0_address_select;
  logic [31:0] cp0_write_data;
  logic        cp0_exception_valid;
  logic [4:0]  cp0_exception_code;
  logic [31:0] cp0_exception_address;
  logic        cp0_in_delay_slot, cp0_eret_flush, ws_flush, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  writeback_stage #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ws_allow_in          (ws_allow_in),
    .ms_pc                (ms_pc),
    .ms_result            (ms_result),
    .ms_dest              (ms_dest),
    .ms_reg_write         (ms_reg_write),
    .ms_exception_valid   (ms_exception_valid),
    .ms_exception_code    (ms_exception_code),
    .ms_in_delay_slot     (ms_in_delay_slot),
    .ms_eret              (ms_eret),
    .ms_mfc0              (ms_mfc0),
    .ms_mtc0              (ms_mtc0),
    .ms_cp0_reg           (ms_cp0_reg),
    .ms_cp0_sel           (ms_cp0_sel),
    .cp0_read_data        (cp0_read_data),
    .cp0_write_enabled    (cp0_write_enabled),
    .cp0_address_register (cp0_address_register),
    .cp0_address_select   (cp0_address_select),
    .cp0_write_data       (cp0_write_data),
    .cp0_exception_valid  (cp0_exception_valid),
    .cp0_exception_code   (cp0_exception_code),
    .cp0_exception_address(cp0_exception_address),
    .cp0_in_delay_slot    (cp0_in_delay_slot),
    .cp0_eret_flush       (cp0_eret_flush),
    .ws_flush             (ws_flush),
    .rf_we                (rf_we),
    .rf_waddr             (rf_waddr),
    .rf_wdata             (rf_wdata),
    .ws_fwd_valid         (ws_fwd_valid),
    .ws_fwd_dest          (ws_fwd_dest)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc          (debug_wb_pc),
    .debug_wb_rf_wen      (debug_wb_rf_wen),
    .debug_wb_rf_wnum     (debug_wb_rf_wnum),
    .debug_wb_rf_wdata    (debug_wb_rf_wdata)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        rw;
    logic        exc;
    logic [4:0]  code;
    logic        ds;
    logic        eret;
    logic        mfc0;
    logic        mtc0;
    logic [4:0]  creg;
    logic [2:0]  csel;
    logic [31:0] crd;
  } vin_t;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        cp0_we;
    logic [4:0]  areg;
    logic [2:0]  asel;
    logic [31:0] cwdata;
    logic        exc_v;
    logic [4:0]  code;
    logic [31:0] addr;
    logic        ds;
    logic        eret_fl;
    logic        flush;
  } vexp_t;

  typedef struct {
    vin_t  i;
    vexp_t e;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic vin_t mkin(input logic v, input logic [31:0] pc, input logic [31:0] res,
                                input logic [4:0] dest, input logic rw, input logic exc,
                                input logic [4:0] code, input logic ds, input logic eret,
                                input logic mfc0, input logic mtc0, input logic [4:0] creg,
                                input logic [2:0] csel, input logic [31:0] crd);
    vin_t r;
    r.valid = v;  r.pc = pc;  r.result = res; r.dest = dest; r.rw = rw; r.exc = exc;
    r.code = code; r.ds = ds; r.eret = eret; r.mfc0 = mfc0; r.mtc0 = mtc0;
    r.creg = creg; r.csel = csel; r.crd = crd;
    return r;
  endfunction

  function automatic vexp_t mkexp(input logic we, input logic [4:0] waddr,
                                  input logic [31:0] wdata, input logic cwe,
                                  input logic [4:0] areg, input logic [2:0] asel,
                                  input logic [31:0] cwdata, input logic excv,
                                  input logic [4:0] code, input logic [31:0] addr,
                                  input logic ds, input logic eretfl, input logic flush);
    vexp_t r;
    r.rf_we = we; r.waddr = waddr; r.wdata = wdata; r.cp0_we = cwe; r.areg = areg;
    r.asel = asel; r.cwdata = cwdata; r.exc_v = excv; r.code = code; r.addr = addr;
    r.ds = ds; r.eret_fl = eretfl; r.flush = flush;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vin_t v);
    ms_to_ws_valid     = v.valid;
    ms_pc              = v.pc;
    ms_result          = v.result;
    ms_dest            = v.dest;
    ms_reg_write       = v.rw;
    ms_exception_valid = v.exc;
    ms_exception_code  = v.code;
    ms_in_delay_slot   = v.ds;
    ms_eret            = v.eret;
    ms_mfc0            = v.mfc0;
    ms_mtc0            = v.mtc0;
    ms_cp0_reg         = v.creg;
    ms_cp0_sel         = v.csel;
  endtask

  task automatic check_all(input string tag, input vexp_t e);
    chk({tag, ".allow_in"}, {31'd0, ws_allow_in}, 32'd1);
    chk({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, e.rf_we});
    chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, e.waddr});
    chk({tag, ".rf_wdata"}, rf_wdata, e.wdata);
    chk({tag, ".fwd_valid"}, {31'd0, ws_fwd_valid}, {31'd0, e.rf_we});
    chk({tag, ".fwd_dest"}, {27'd0, ws_fwd_dest}, {27'd0, e.waddr});
    chk({tag, ".cp0_we"}, {31'd0, cp0_write_enabled}, {31'd0, e.cp0_we});
    chk({tag, ".cp0_areg"}, {27'd0, cp0_address_register}, {27'd0, e.areg});
    chk({tag, ".cp0_asel"}, {29'd0, cp0_address_select}, {29'd0, e.asel});
    chk({tag, ".cp0_wdata"}, cp0_write_data, e.cwdata);
    chk({tag, ".exc_valid"}, {31'd0, cp0_exception_valid}, {31'd0, e.exc_v});
    chk({tag, ".exc_code"}, {27'd0, cp0_exception_code}, {27'd0, e.code});
    chk({tag, ".exc_addr"}, cp0_exception_address, e.addr);
    chk({tag, ".in_ds"}, {31'd0, cp0_in_delay_slot}, {31'd0, e.ds});
    chk({tag, ".eret_flush"}, {31'd0, cp0_eret_flush}, {31'd0, e.eret_fl});
    chk({tag, ".ws_flush"}, {31'd0, ws_flush}, {31'd0, e.flush});
`ifdef WB_DEBUG_TRACE_EN
    chk({tag, ".dbg_wen"}, {28'd0, debug_wb_rf_wen}, {28'd0, {4{e.rf_we}}});
    chk({tag, ".dbg_wdata"}, debug_wb_rf_wdata, e.wdata);
`endif
  endtask

  vec_t  vecs[9];
  vexp_t zero_e;
  vin_t  idle_i;

  initial begin
    zero_e = mkexp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_i = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //             v  pc            result        dst rw exc code ds er mf mt creg sel crd
    vecs[0].i = mkin(1, 32'hBFC00100, 32'h12345678, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[0].e = mkexp(1, 3, 32'h12345678, 0, 0, 0, 32'h12345678, 0, 0, 32'hBFC00100, 0, 0, 0);
    vecs[1].i = mkin(1, 32'hBFC00104, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[1].e = mkexp(0, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'hBFC00104, 0, 0, 0);
    vecs[2].i = mkin(1, 32'hBFC00108, 32'h00000042, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vecs[2].e = mkexp(0, 9, 32'h00000042, 0, 0, 0, 32'h00000042, 0, 0, 32'hBFC00108, 0, 0, 0);
    vecs[3].i = mkin(1, 32'hBFC0010C, 32'h00001111, 4, 1, 0, 0, 0, 0, 1, 0, 9, 0, 32'hA5A50000);
    vecs[3].e = mkexp(1, 4, 32'hA5A50000, 0, 9, 0, 32'h00001111, 0, 0, 32'hBFC0010C, 0, 0, 0);
    vecs[4].i = mkin(1, 32'hBFC00200, 32'h00000005, 3, 1, 1, 8, 1, 0, 0, 1, 12, 0, 32'h0);
    vecs[4].e = mkexp(0, 3, 32'h00000005, 0, 12, 0, 32'h00000005, 1, 8, 32'hBFC00200, 1, 0, 1);
    vecs[5].i = mkin(1, 32'hBFC00300, 32'h00000077, 2, 1, 0, 0, 0, 1, 0, 1, 14, 0, 32'h0);
    vecs[5].e = mkexp(0, 2, 32'h00000077, 0, 14, 0, 32'h00000077, 0, 0, 32'hBFC00300, 0, 1, 1);
    vecs[6].i = mkin(1, 32'hBFC00400, 32'h00000000, 0, 0, 1, 5'h0C, 0, 1, 0, 0, 0, 0, 32'h0);
    vecs[6].e = mkexp(0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 5'h0C, 32'hBFC00400, 0, 0, 1);
    vecs[7].i = mkin(1, 32'hBFC00500, 32'h0000CAFE, 0, 0, 0, 0, 0, 0, 0, 1, 12, 3, 32'h0);
    vecs[7].e = mkexp(0, 0, 32'h0000CAFE, 1, 12, 3, 32'h0000CAFE, 0, 0, 32'hBFC00500, 0, 0, 0);
    vecs[8].i = mkin(0, 32'hBFC00600, 32'h0000BEEF, 6, 1, 1, 3, 1, 1, 1, 1, 7, 7, 32'h12121212);
    vecs[8].e = zero_e;

    reset         = 1'b1;
    cp0_read_data = 32'h0;
    drive(idle_i);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 check_all("reset", zero_e);

    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].i);
      @(posedge clock);
      #1;
      ms_to_ws_valid = 1'b0;
      cp0_read_data  = vecs[k].i.crd;
      #1 check_all($sformatf("vec%0d", k), vecs[k].e);
      // Idle cycle so a flushing vector cannot drop the next one.
      @(posedge clock);
      #1;
    end

    // MTC0 then MFC0 of the same register in back-to-back cycles.
    drive(mkin(1, 32'hBFC00700, 32'h0000FF01, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 32'h0));
    cp0_read_data = 32'h0;
    @(posedge clock);
    #1 drive(mkin(1, 32'hBFC00704, 32'h0, 5, 1, 0, 0, 0, 0, 1, 0, 12, 0, 32'h0));
    #1 check_all("mtc0", mkexp(0, 0, 32'h0000FF01, 1, 12, 0, 32'h0000FF01, 0, 0, 32'hBFC00700,
                                0, 0, 0));
    @(posedge clock);
    #1 drive(idle_i);
    cp0_read_data = 32'h0040FF01;
    #1 check_all("mfc0", mkexp(1, 5, 32'h0040FF01, 0, 12, 0, 32'h0, 0, 0, 32'hBFC00704,
                                0, 0, 0));
    @(posedge clock);
    #1 cp0_read_data = 32'h0;

    // Exception commit drops the instruction presented in the same cycle.
    drive(mkin(1, 32'hBFC00200, 32'h0, 3, 1, 1, 8, 1, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clock);
    #1 drive(mkin(1, 32'hBFC00800, 32'h00000077, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    #1 check_all("exc", mkexp(0, 3, 32'h0, 0, 0, 0, 32'h0, 1, 8, 32'hBFC00200, 1, 0, 1));
    @(posedge clock);
    #1 drive(idle_i);
    #1 check_all("dropped", zero_e);

    // Reset while an exception is committing: no CP0 side effect.
    drive(mkin(1, 32'hBFC00900, 32'h0, 3, 1, 1, 4, 0, 0, 0, 0, 0, 0, 32'h0));
    @(posedge clock);
    #1 drive(idle_i);
    reset = 1'b1;
    #1 chk("rst_cycle.exc_valid", {31'd0, cp0_exception_valid}, 32'd0);
    chk("rst_cycle.ws_flush", {31'd0, ws_flush}, 32'd0);
    chk("rst_cycle.rf_we", {31'd0, rf_we}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_all("post_reset", zero_e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
